s27_resp_compactor: RTL and testbench

//  Downstream response-capture stage for the s27 core. It samples the G17 output stream over a fixed window of

---
 rtl/s27_resp_compactor.sv | 82 ++++++++
 tb/tb_s27_resp_compactor.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/s27_resp_compactor.sv
// Response-capture stage for the s27 G17 output: compacts a fixed window of qualified samples
// into a MISR signature, a ones count and a toggle count.
module s27_resp_compactor #(
    parameter int unsigned       SIG_W   = 16,
    parameter logic [SIG_W-1:0]  POLY    = 16'h1021,
    parameter logic [SIG_W-1:0]  SEED    = 16'h0000,
    parameter int unsigned       WIN_LEN = 256,
    parameter int unsigned       CNT_W   = 16
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             START,
    input  logic             G17,
    input  logic             VALID_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [SIG_W-1:0] SIG_OUT,
    output logic [CNT_W-1:0] ONES_CNT,
    output logic [CNT_W-1:0] TOGGLE_CNT
);

    localparam int unsigned SC_W = $clog2(WIN_LEN + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [SIG_W-1:0]  sig_q;
    logic [CNT_W-1:0]  ones_q, tog_q;
    logic [SC_W-1:0]   cnt_q;
    logic              prev_q;
    logic              take, open, last;

    assign open = (state_q != StRun) && START;
    assign take = (state_q == StRun) && VALID_IN;
    assign last = (cnt_q == SC_W'(WIN_LEN - 1));

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (START) state_d = StRun;
            StRun:   if (VALID_IN && last) state_d = StDone;
            StDone:  if (START) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        BUSY = (state_q == StRun);
        DONE = (state_q == StDone);
    end

    always_ff @(posedge CK) begin
        if (RST || open) begin
            sig_q  <= SEED;
            ones_q <= '0;
            tog_q  <= '0;
            cnt_q  <= '0;
            prev_q <= 1'b0;
        end else if (take) begin
            sig_q  <= {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0)
                      ^ {{(SIG_W-1){1'b0}}, G17};
            // Counters stick at all-ones rather than wrap
            if (G17 && ones_q != '1) ones_q <= ones_q + 1'b1;
            if ((G17 != prev_q) && tog_q != '1) tog_q <= tog_q + 1'b1;
            prev_q <= G17;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign SIG_OUT    = sig_q;
    assign ONES_CNT   = ones_q;
    assign TOGGLE_CNT = tog_q;

endmodule

// File: tb/tb_s27_resp_compactor.sv
// Randomised and directed checks of s27_resp_compactor against a queue-based window model.
module tb_s27_resp_compactor;

    localparam int unsigned WIN = 8;
    localparam logic [15:0] POLY_C = 16'h1021;

    logic        CK = 0, RST = 1, START = 0, G17 = 0, VALID_IN = 0;
    logic        BUSY, DONE;
    logic [15:0] SIG_OUT, ONES_CNT, TOGGLE_CNT;

    s27_resp_compactor #(.WIN_LEN(WIN)) dut (
        .CK(CK), .RST(RST), .START(START), .G17(G17), .VALID_IN(VALID_IN),
        .BUSY(BUSY), .DONE(DONE), .SIG_OUT(SIG_OUT), .ONES_CNT(ONES_CNT),
        .TOGGLE_CNT(TOGGLE_CNT)
    );

    always #5 CK = ~CK;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 0;

    // Model: mode 0 idle, 1 window open, 2 window closed; samples of the current window
    int m_mode = 0;
    bit samples[$];

    function automatic logic [15:0] exp_sig();
        logic [15:0] s = 16'h0000;
        foreach (samples[i]) s = {s[14:0], 1'b0} ^ (s[15] ? POLY_C : 16'h0) ^ {15'd0, samples[i]};
        return s;
    endfunction

    function automatic int exp_ones();
        int n = 0;
        foreach (samples[i]) n += samples[i];
        return n;
    endfunction

    function automatic int exp_tog();
        int n = 0;
        bit p = 0;
        foreach (samples[i]) begin
            if (samples[i] != p) n++;
            p = samples[i];
        end
        return n;
    endfunction

    always @(posedge CK) begin
        if (RST) begin
            m_mode = 0;
            samples.delete();
        end else if (m_mode != 1 && START) begin
            m_mode = 1;
            samples.delete();
        end else if (m_mode == 1 && VALID_IN) begin
            samples.push_back(G17);
            if (samples.size() == WIN) m_mode = 2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge CK) begin
        if (chk_en) begin
            check("busy", {31'd0, BUSY}, {31'd0, m_mode == 1});
            check("done", {31'd0, DONE}, {31'd0, m_mode == 2});
            check("sig", {16'd0, SIG_OUT}, {16'd0, exp_sig()});
            check("ones", {16'd0, ONES_CNT}, exp_ones());
            check("toggle", {16'd0, TOGGLE_CNT}, exp_tog());
        end
    end

    task automatic step(input logic r, input logic s, input logic g, input logic v);
        RST = r; START = s; G17 = g; VALID_IN = v;
        @(posedge CK);
        #2;
    endtask

    task automatic lit(input string name, input logic b, input logic d, input logic [15:0] sig,
                       input logic [15:0] ones, input logic [15:0] tog);
        check({name, "_busy"}, {31'd0, BUSY}, {31'd0, b});
        check({name, "_done"}, {31'd0, DONE}, {31'd0, d});
        check({name, "_sig"}, {16'd0, SIG_OUT}, {16'd0, sig});
        check({name, "_ones"}, {16'd0, ONES_CNT}, {16'd0, ones});
        check({name, "_tog"}, {16'd0, TOGGLE_CNT}, {16'd0, tog});
    endtask

    initial begin
        step(1, 0, 0, 0);
        chk_en = 1;
        step(1, 0, 0, 0);
        lit("reset", 0, 0, 16'h0000, 0, 0);

        // Reset in the middle of a window
        step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
        step(1, 0, 1, 1);
        lit("midreset", 0, 0, 16'h0000, 0, 0);

        // All-zero window
        step(0, 1, 1, 1);
        for (int i = 0; i < WIN; i++) step(0, 0, 0, 1);
        lit("zeros", 0, 1, 16'h0000, 0, 0);

        // Single leading one
        step(0, 1, 0, 0);
        for (int i = 0; i < WIN; i++) step(0, 0, i == 0, 1);
        lit("one_first", 0, 1, 16'h0080, 1, 2);

        // All ones
        step(0, 1, 0, 0);
        for (int i = 0; i < WIN; i++) step(0, 0, 1, 1);
        lit("ones", 0, 1, 16'h00FF, 8, 1);

        // Alternating data with gaps in the qualifier
        step(0, 1, 0, 0);
        for (int i = 0; i < 16; i++)
            step(0, 0, (i % 2 == 0) ? ((i / 2) % 2 == 0) : 1'($urandom), i % 2 == 0);
        lit("alt", 0, 1, 16'h00AA, 4, 8);

        // START during RUN is ignored, START in DONE opens a new window
        step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        lit("start_in_run", 1, 0, 16'h0000, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        lit("start_ignored", 0, 1, 16'h0000, 0, 0);
        step(0, 0, 1, 1);
        lit("done_frozen", 0, 1, 16'h0000, 0, 0);
        step(0, 1, 1, 1);
        lit("restart", 1, 0, 16'h0000, 0, 0);

        // Random traffic
        for (int i = 0; i < 4000; i++)
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 15) == 0),
                 1'($urandom), ($urandom_range(0, 2) != 0));

        step(0, 0, 0, 0);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
